csr_decode: RTL and testbench



---
 rtl/csr_decode_pkg.sv | 22 ++
 rtl/csr_decode_legal_chk.sv | 29 ++
 rtl/csr_decode.sv | 99 +++++++++
 tb/tb_csr_decode.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_decode_pkg.sv
// Shared constants for the CSR issue stage: SYSTEM opcode, CSR funct3 codes,
// read-only address field and FSM state encoding.
package csr_decode_pkg;

  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [2:0] INST_CSRRW  = 3'b001;
  localparam logic [2:0] INST_CSRRS  = 3'b010;
  localparam logic [2:0] INST_CSRRC  = 3'b011;
  localparam logic [2:0] INST_CSRRWI = 3'b101;
  localparam logic [2:0] INST_CSRRSI = 3'b110;
  localparam logic [2:0] INST_CSRRCI = 3'b111;

  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RS1   = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/csr_decode_legal_chk.sv
// Combinational CSR legality / write-intent check (module csr_legal_chk).
// Flags only SYSTEM-opcode words; non-SYSTEM words are never illegal here.
module csr_legal_chk
  import csr_decode_pkg::*;
(
  input  logic [31:0] inst,
  output logic        illegal,
  output logic        wr_intent,
  output logic        is_imm
);

  logic unused_fields;
  assign unused_fields = ^{inst[29:20], inst[11:7]};

  assign is_imm = inst[14];

  always_comb begin
    wr_intent = 1'b0;
    illegal   = 1'b0;
    unique case (inst[14:12])
      INST_CSRRW, INST_CSRRWI: wr_intent = 1'b1;
      INST_CSRRS, INST_CSRRC, INST_CSRRSI, INST_CSRRCI: wr_intent = |inst[19:15];
      default: illegal = 1'b1;
    endcase
    if ((inst[31:30] == CSR_RO_FIELD) && wr_intent) illegal = 1'b1;
    if (inst[6:0] != OPCODE_SYSTEM) illegal = 1'b0;
  end

endmodule

// File: rtl/csr_decode.sv
// CSR issue stage: decodes SYSTEM CSR words, fetches rs1, issues to the CSR unit.
// Optional CSR_DECODE_PERF_EN adds issue / illegal event counters.
module csr_decode
  import csr_decode_pkg::*;
#(
  parameter int unsigned MXLEN      = 32,
  parameter int unsigned CSR_ADDR_W = 12
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_inst_valid,
  input  logic [31:0]           i_inst,
  output logic                  o_inst_ready,
  output logic [4:0]            o_rs1_addr,
  input  logic [MXLEN-1:0]      i_rs1_gpr_data,
  output logic                  o_csr_valid,
  input  logic                  i_csr_ready,
  output logic [CSR_ADDR_W-1:0] o_csr_addr,
  output logic [4:0]            o_rs1_addr_uimm,
  output logic [4:0]            o_rd_addr,
  output logic [MXLEN-1:0]      o_rs1_data,
  output logic [2:0]            o_funct3,
  output logic                  o_illegal,
  output logic [31:0]           o_illegal_inst
`ifdef CSR_DECODE_PERF_EN
  ,
  output logic [31:0]           o_issue_cnt,
  output logic [31:0]           o_illegal_cnt
`endif
);

  state_t state, next_state;
  logic   chk_illegal, chk_wr_intent, chk_imm;
  logic   take;

  csr_legal_chk u_legal_chk (
    .inst      (i_inst),
    .illegal   (chk_illegal),
    .wr_intent (chk_wr_intent),
    .is_imm    (chk_imm)
  );

  logic unused_wr;
  assign unused_wr = chk_wr_intent;

  assign take         = (state == ST_IDLE) && i_inst_valid && (i_inst[6:0] == OPCODE_SYSTEM);
  assign o_inst_ready = (state == ST_IDLE);
  assign o_csr_valid  = (state == ST_ISSUE);
  assign o_rs1_addr   = take ? i_inst[19:15] : '0;

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (take && !chk_illegal) next_state = chk_imm ? ST_ISSUE : ST_RS1;
      ST_RS1:   next_state = ST_ISSUE;
      ST_ISSUE: if (i_csr_ready) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state           <= ST_IDLE;
      o_csr_addr      <= '0;
      o_rs1_addr_uimm <= '0;
      o_rd_addr       <= '0;
      o_funct3        <= '0;
      o_rs1_data      <= '0;
      o_illegal       <= 1'b0;
      o_illegal_inst  <= '0;
    end else begin
      state     <= next_state;
      o_illegal <= take && chk_illegal;
      if (take && chk_illegal) o_illegal_inst <= i_inst;
      // Fields only load on acceptance, so they stay frozen through ISSUE stalls.
      if (take && !chk_illegal) begin
        o_csr_addr      <= i_inst[31 -: CSR_ADDR_W];
        o_rs1_addr_uimm <= i_inst[19:15];
        o_rd_addr       <= i_inst[11:7];
        o_funct3        <= i_inst[14:12];
        if (chk_imm) o_rs1_data <= {{(MXLEN-5){1'b0}}, i_inst[19:15]};
      end
      if (state == ST_RS1) o_rs1_data <= i_rs1_gpr_data;
    end
  end

`ifdef CSR_DECODE_PERF_EN
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_issue_cnt   <= '0;
      o_illegal_cnt <= '0;
    end else begin
      if (o_csr_valid && i_csr_ready) o_issue_cnt <= o_issue_cnt + 32'd1;
      if (o_illegal) o_illegal_cnt <= o_illegal_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_csr_decode.sv
// Directed, table-driven bench for csr_decode (plus stall and reset sequences).
module tb_csr_decode;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = '0;
  logic        inst_ready;
  logic [4:0]  rs1_addr;
  logic [31:0] gpr_data = '0;
  logic        csr_valid;
  logic        csr_ready = 1'b1;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_uimm;
  logic [4:0]  rd_addr;
  logic [31:0] rs1_data;
  logic [2:0]  funct3;
  logic        illegal;
  logic [31:0] illegal_inst;
`ifdef CSR_DECODE_PERF_EN
  logic [31:0] issue_cnt, illegal_cnt;
`endif

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned exp_issues = 0;
  int unsigned exp_illegals = 0;

  logic [31:0] gpr [32];

  always #5 clk = ~clk;

  // Registered GPR read port, one-cycle latency.
  always @(posedge clk) gpr_data <= gpr[rs1_addr];

  csr_decode #(.MXLEN(32), .CSR_ADDR_W(12)) dut (
    .i_clk           (clk),
    .i_nrst          (nrst),
    .i_inst_valid    (inst_valid),
    .i_inst          (inst),
    .o_inst_ready    (inst_ready),
    .o_rs1_addr      (rs1_addr),
    .i_rs1_gpr_data  (gpr_data),
    .o_csr_valid     (csr_valid),
    .i_csr_ready     (csr_ready),
    .o_csr_addr      (csr_addr),
    .o_rs1_addr_uimm (rs1_uimm),
    .o_rd_addr       (rd_addr),
    .o_rs1_data      (rs1_data),
    .o_funct3        (funct3),
    .o_illegal       (illegal),
    .o_illegal_inst  (illegal_inst)
`ifdef CSR_DECODE_PERF_EN
    ,
    .o_issue_cnt     (issue_cnt),
    .o_illegal_cnt   (illegal_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input logic [11:0] a, input logic [4:0] u,
                            input logic [4:0] r, input logic [2:0] f, input logic [31:0] d);
    chk({tag, " csr_addr"}, {20'd0, csr_addr}, {20'd0, a});
    chk({tag, " uimm"}, {27'd0, rs1_uimm}, {27'd0, u});
    chk({tag, " rd"}, {27'd0, rd_addr}, {27'd0, r});
    chk({tag, " funct3"}, {29'd0, funct3}, {29'd0, f});
    chk({tag, " rs1_data"}, rs1_data, d);
  endtask

  // kind: 0 dropped, 1 immediate form, 2 register form, 3 illegal
  typedef struct {
    logic [31:0] inst;
    int          kind;
    logic [11:0] addr;
    logic [4:0]  uimm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] rs1d;
  } vec_t;

  vec_t vecs [10];

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = 32'hA500_0000 | i;
    gpr[0] = 32'h0;
    gpr[6] = 32'hDEAD_BEEF;

    vecs[0] = '{32'h340312F3, 2, 12'h340, 5'd6, 5'd5,  3'd1, 32'hDEADBEEF}; // CSRRW x5,0x340,x6
    vecs[1] = '{32'h3002D1F3, 1, 12'h300, 5'd5, 5'd3,  3'd5, 32'h00000005}; // CSRRWI x3,0x300,5
    vecs[2] = '{32'hF11110F3, 3, 12'h000, 5'd2, 5'd0,  3'd0, 32'h0};        // CSRRW to RO csr
    vecs[3] = '{32'hF1102073, 2, 12'hF11, 5'd0, 5'd0,  3'd2, 32'h0};        // CSRRS x0,0xF11,x0
    vecs[4] = '{32'h00000073, 3, 12'h000, 5'd0, 5'd0,  3'd0, 32'h0};        // funct3 000
    vecs[5] = '{32'h30004073, 3, 12'h000, 5'd0, 5'd0,  3'd0, 32'h0};        // funct3 100
    vecs[6] = '{32'h00000013, 0, 12'h000, 5'd0, 5'd0,  3'd0, 32'h0};        // non-SYSTEM
    vecs[7] = '{32'hC0006073, 1, 12'hC00, 5'd0, 5'd0,  3'd6, 32'h0};        // CSRRSI RO, uimm 0
    vecs[8] = '{32'hC000F073, 3, 12'h000, 5'd1, 5'd0,  3'd0, 32'h0};        // CSRRCI RO, uimm 1
    vecs[9] = '{32'h3401B573, 2, 12'h340, 5'd3, 5'd10, 3'd3, 32'hA5000003}; // CSRRC x10,0x340,x3

    #2;
    chk("reset inst_ready", {31'd0, inst_ready}, 32'd1);
    chk("reset csr_valid", {31'd0, csr_valid}, 32'd0);
    chk("reset illegal", {31'd0, illegal}, 32'd0);
    chk("reset illegal_inst", illegal_inst, 32'd0);
    chk_fields("reset", 12'h0, 5'd0, 5'd0, 3'd0, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      inst = vecs[k].inst;
      inst_valid = 1'b1;
      #1;
      chk($sformatf("v%0d inst_ready", k), {31'd0, inst_ready}, 32'd1);
      chk($sformatf("v%0d rs1_addr", k), {27'd0, rs1_addr},
          (vecs[k].kind == 0) ? 32'd0 : {27'd0, vecs[k].uimm});
      @(negedge clk);
      inst_valid = 1'b0;
      chk($sformatf("v%0d illegal", k), {31'd0, illegal}, (vecs[k].kind == 3) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d csr_valid T+1", k), {31'd0, csr_valid}, (vecs[k].kind == 1) ? 32'd1 : 32'd0);
      if (vecs[k].kind == 3) begin
        exp_illegals++;
        chk($sformatf("v%0d illegal_inst", k), illegal_inst, vecs[k].inst);
      end
      if (vecs[k].kind == 2) begin
        @(negedge clk);
        chk($sformatf("v%0d csr_valid T+2", k), {31'd0, csr_valid}, 32'd1);
      end
      if (vecs[k].kind == 1 || vecs[k].kind == 2) begin
        exp_issues++;
        chk_fields($sformatf("v%0d", k), vecs[k].addr, vecs[k].uimm, vecs[k].rd, vecs[k].f3, vecs[k].rs1d);
      end
      @(negedge clk);
      chk($sformatf("v%0d csr_valid after", k), {31'd0, csr_valid}, 32'd0);
      chk($sformatf("v%0d illegal after", k), {31'd0, illegal}, 32'd0);
      chk($sformatf("v%0d inst_ready after", k), {31'd0, inst_ready}, 32'd1);
    end

`ifdef CSR_DECODE_PERF_EN
    chk("issue_cnt", issue_cnt, exp_issues);
    chk("illegal_cnt", illegal_cnt, exp_illegals);
`endif

    // Backpressure: CSRRW x5,0x340,x6 held in ISSUE for 4 cycles.
    csr_ready = 1'b0;
    @(negedge clk);
    inst = 32'h340312F3;
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    chk("bp csr_valid", {31'd0, csr_valid}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        inst = 32'h3002D1F3;
        inst_valid = 1'b1;
        #1;
        chk("bp ignored rs1_addr", {27'd0, rs1_addr}, 32'd0);
      end
      @(negedge clk);
      inst_valid = 1'b0;
      chk($sformatf("bp%0d csr_valid", c), {31'd0, csr_valid}, 32'd1);
      chk($sformatf("bp%0d inst_ready", c), {31'd0, inst_ready}, 32'd0);
      chk_fields($sformatf("bp%0d", c), 12'h340, 5'd6, 5'd5, 3'd1, 32'hDEADBEEF);
    end
    csr_ready = 1'b1;
    @(negedge clk);
    exp_issues++;
    chk("bp done csr_valid", {31'd0, csr_valid}, 32'd0);
    chk("bp done inst_ready", {31'd0, inst_ready}, 32'd1);
    @(negedge clk);
    chk("bp no phantom issue", {31'd0, csr_valid}, 32'd0);
    @(negedge clk);
    chk("bp no phantom issue 2", {31'd0, csr_valid}, 32'd0);

`ifdef CSR_DECODE_PERF_EN
    chk("issue_cnt bp", issue_cnt, exp_issues);
`endif

    // Reset while stalled in ISSUE.
    csr_ready = 1'b0;
    inst = 32'hF1102073;
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    chk("rst pre csr_valid", {31'd0, csr_valid}, 32'd1);
    chk("rst pre csr_addr", {20'd0, csr_addr}, 32'h0000_0F11);
    #2;
    nrst = 1'b0;
    #1;
    chk("rst csr_valid", {31'd0, csr_valid}, 32'd0);
    chk("rst inst_ready", {31'd0, inst_ready}, 32'd1);
    chk("rst csr_addr", {20'd0, csr_addr}, 32'd0);
    chk("rst illegal_inst", illegal_inst, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    csr_ready = 1'b1;
`ifdef CSR_DECODE_PERF_EN
    chk("rst issue_cnt", issue_cnt, 32'd0);
    chk("rst illegal_cnt", illegal_cnt, 32'd0);
`endif
    @(negedge clk);
    chk("post rst csr_valid", {31'd0, csr_valid}, 32'd0);
    inst = 32'h3002D1F3;
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    chk("post rst imm issue", {31'd0, csr_valid}, 32'd1);
    chk_fields("post rst", 12'h300, 5'd5, 5'd3, 3'd5, 32'd5);
    @(negedge clk);
    chk("post rst idle", {31'd0, inst_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
